// File: rtl/decode_stage_if.sv
// decode_stage_if: fetch/writeback inputs and decode/execute outputs of the decode stage
interface decode_stage_if #(parameter int DATA_W = 16);
  logic [DATA_W-1:0] instruction_in;
  logic [DATA_W-1:0] pc_in;
  logic              valid_in;
  logic              stall_in;
  logic              flush_in;
  logic              wb_en;
  logic [3:0]        wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              hazard_stall;
  logic              valid_out;
  logic [3:0]        opcode_out;
  logic [3:0]        rd_out;
  logic [DATA_W-1:0] rs_a_data;
  logic [DATA_W-1:0] rs_b_data;
  logic [DATA_W-1:0] imm_out;
  logic [DATA_W-1:0] pc_out;
  logic              reg_write;
  logic              mem_read;
  logic              mem_write;
  logic              branch;
  logic              jump;
  logic              illegal_out;
  modport slave (
    input  instruction_in, pc_in, valid_in, stall_in, flush_in, wb_en, wb_addr, wb_data,
    output hazard_stall, valid_out, opcode_out, rd_out, rs_a_data, rs_b_data, imm_out, pc_out,
           reg_write, mem_read, mem_write, branch, jump, illegal_out
  );
  modport master (
    output instruction_in, pc_in, valid_in, stall_in, flush_in, wb_en, wb_addr, wb_data,
    input  hazard_stall, valid_out, opcode_out, rd_out, rs_a_data, rs_b_data, imm_out, pc_out,
           reg_write, mem_read, mem_write, branch, jump, illegal_out
  );
endinterface

// File: rtl/decode_stage.sv
// decode_stage: register file, opcode decode, load-use hazard detection and decode/execute register
module decode_stage #(
  parameter int DATA_W    = 16,
  parameter int REG_COUNT = 16
) (
  input logic           clk,
  input logic           reset,
  decode_stage_if.slave bus
);
  typedef struct packed {
    logic              valid;
    logic [3:0]        op;
    logic [3:0]        rd;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] pc;
    logic              rw;
    logic              mr;
    logic              mw;
    logic              br;
    logic              jp;
    logic              ill;
  } de_t;
  logic [DATA_W-1:0] rf_q [REG_COUNT];
  de_t de_q, de_d, dec, bub;
  logic [DATA_W-1:0] ins, rd_a, rd_b, imm;
  logic [3:0] op, addr_a, addr_b;
  logic legal, v, ill, uses_a, uses_b, hz;
  assign ins    = bus.instruction_in;
  assign op     = ins[15:12];
  assign legal  = op <= 4'd9;
  assign v      = bus.valid_in & legal;
  assign ill    = bus.valid_in & ~legal;
  assign addr_a = ins[7:4];
  assign addr_b = (op == 4'd7 || op == 4'd8) ? ins[11:8] : ins[3:0];
  assign uses_a = op >= 4'd1 && op <= 4'd8;
  assign uses_b = (op >= 4'd1 && op <= 4'd4) || op == 4'd7 || op == 4'd8;
  // Reads see a same-cycle writeback so the pipeline needs no extra forwarding from WB
  assign rd_a = addr_a == 4'd0 ? '0 : (bus.wb_en && bus.wb_addr == addr_a) ? bus.wb_data : rf_q[addr_a];
  assign rd_b = addr_b == 4'd0 ? '0 : (bus.wb_en && bus.wb_addr == addr_b) ? bus.wb_data : rf_q[addr_b];
  assign imm  = op == 4'd9 ? {{(DATA_W-12){ins[11]}}, ins[11:0]} :
                (op >= 4'd5 && op <= 4'd8) ? {{(DATA_W-4){ins[3]}}, ins[3:0]} : '0;
  assign hz = bus.valid_in & de_q.valid & de_q.mr & (|de_q.rd) &
              ((uses_a & (de_q.rd == addr_a)) | (uses_b & (de_q.rd == addr_b)));
  always_comb begin
    dec       = '0;
    dec.valid = v;
    dec.op    = op;
    dec.rd    = (op >= 4'd1 && op <= 4'd6) ? ins[11:8] : 4'd0;
    dec.a     = rd_a;
    dec.b     = rd_b;
    dec.imm   = imm;
    dec.pc    = bus.pc_in;
    dec.rw    = v & (op >= 4'd1 && op <= 4'd6);
    dec.mr    = v & (op == 4'd6);
    dec.mw    = v & (op == 4'd7);
    dec.br    = v & (op == 4'd8);
    dec.jp    = v & (op == 4'd9);
    bub       = '0;
    bub.ill   = ill;
    de_d      = bus.flush_in ? '0 : bus.stall_in ? de_q : (hz | ill) ? bub : dec;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      de_q <= '0;
      for (int i = 0; i < REG_COUNT; i++) rf_q[i] <= '0;
    end else begin
      de_q <= de_d;
      if (bus.wb_en && bus.wb_addr != 4'd0) rf_q[bus.wb_addr] <= bus.wb_data;
    end
  end
  assign bus.hazard_stall = hz;
  assign bus.valid_out    = de_q.valid;
  assign bus.opcode_out   = de_q.op;
  assign bus.rd_out       = de_q.rd;
  assign bus.rs_a_data    = de_q.a;
  assign bus.rs_b_data    = de_q.b;
  assign bus.imm_out      = de_q.imm;
  assign bus.pc_out       = de_q.pc;
  assign bus.reg_write    = de_q.rw;
  assign bus.mem_read     = de_q.mr;
  assign bus.mem_write    = de_q.mw;
  assign bus.branch       = de_q.br;
  assign bus.jump         = de_q.jp;
  assign bus.illegal_out  = de_q.ill;
endmodule
